// File: rtl/tx_credit_arbiter.sv
// tx_credit_arbiter
//
// Shares one UART transmitter among NUM_REQ byte producers. A round-robin
// search picks one requester, its byte is latched and offered downstream on
// a valid/ready handshake. Bytes accepted by the transmitter but not yet
// finished on the wire are counted, and no new byte is issued while that
// count sits at MAX_OUTSTANDING.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req               per-requester level request
//   req_data          requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt               one-hot, one-cycle pulse: that requester's byte latched
//   tx_valid/tx_data  byte offered to the transmitter, held until accepted
//   tx_ready          transmitter accepts when tx_valid && tx_ready
//   tx_done           one-cycle pulse: one accepted byte finished on the wire
//   outstanding       accepted-but-not-done count
//   credit_full       outstanding == MAX_OUTSTANDING
//   underflow_err     sticky: tx_done seen while outstanding was 0
module tx_credit_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    input  logic                          tx_done,
    output logic [CNT_WIDTH-1:0]          outstanding,
    output logic                          credit_full,
    output logic                          underflow_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]     PTR_RESET = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]   outstanding_q, outstanding_d;
    logic                   credit_full_q, credit_full_d;
    logic                   underflow_err_q, underflow_err_d;

    logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];
    logic [PTR_W-1:0]       win_idx;
    logic                   win_found;
    logic                   accept;

    // Unpack the flat request data bus so the winner can be indexed directly.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: the first set request starting just after the last
    // winner, wrapping modulo NUM_REQ, so the last winner has lowest priority.
    always_comb begin
        int cand;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!win_found && req[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign accept = tx_valid_q && tx_ready;

    // Issue FSM. Requests are only sampled in IDLE, and only while a credit
    // is free; the offered byte is then held in ISSUE until the handshake.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found && (outstanding_q < MAX_CNT)) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    tx_data_d      = req_bytes[win_idx];
                    tx_valid_d     = 1'b1;
                    rr_ptr_d       = win_idx;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Outstanding counter. A simultaneous accept and done cancel out. A done
    // with nothing outstanding cannot decrement, so it latches the sticky
    // error instead. credit_full is derived from the next count so it never
    // lags outstanding by a cycle.
    always_comb begin
        outstanding_d   = outstanding_q;
        underflow_err_d = underflow_err_q;
        if (accept && !tx_done) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (tx_done && !accept) begin
            if (outstanding_q == '0) begin
                underflow_err_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - 1'b1;
            end
        end
        credit_full_d = (outstanding_d == MAX_CNT);
    end

    // State register; reset discards any byte pending in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            gnt_q           <= '0;
            tx_valid_q      <= 1'b0;
            tx_data_q       <= '0;
            rr_ptr_q        <= PTR_RESET;
            outstanding_q   <= '0;
            credit_full_q   <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            tx_valid_q      <= tx_valid_d;
            tx_data_q       <= tx_data_d;
            rr_ptr_q        <= rr_ptr_d;
            outstanding_q   <= outstanding_d;
            credit_full_q   <= credit_full_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign gnt           = gnt_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign outstanding   = outstanding_q;
    assign credit_full   = credit_full_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_tx_credit_arbiter.sv
// tb_tx_credit_arbiter
//
// Directed testbench for tx_credit_arbiter (NUM_REQ=4, MAX_OUTSTANDING=4,
// CNT_WIDTH=3). Inputs change and outputs are sampled on the falling edge,
// half a cycle away from the rising edge the design uses.
module tb_tx_credit_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int CNT_WIDTH  = 3;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          tx_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_ready;
    logic                          tx_done;
    logic [CNT_WIDTH-1:0]          outstanding;
    logic                          credit_full;
    logic                          underflow_err;

    int tests_run;
    int tests_failed;

    tx_credit_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_OUTSTANDING(4),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .outstanding(outstanding),
        .credit_full(credit_full),
        .underflow_err(underflow_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upper bound on run time so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to the next falling edge (one rising edge in between).
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_ready = 1'b0;
        tx_done  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Reset state of every output.
    task automatic test_reset();
        do_reset();
        tests_run++;
        if (gnt !== 4'b0000) begin
            $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); tests_failed++;
        end
        tests_run++;
        if (tx_valid !== 1'b0) begin
            $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); tests_failed++;
        end
        tests_run++;
        if (tx_data !== 8'h00) begin
            $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); tests_failed++;
        end
        tests_run++;
        if (outstanding !== 3'd0) begin
            $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); tests_failed++;
        end
        tests_run++;
        if (credit_full !== 1'b0) begin
            $display("[TB] FAIL reset_credit_full: got %b expected 0", credit_full); tests_failed++;
        end
        tests_run++;
        if (underflow_err !== 1'b0) begin
            $display("[TB] FAIL reset_underflow_err: got %b expected 0", underflow_err); tests_failed++;
        end
    endtask

    // One requester, one byte: grant latency and counter latency.
    task automatic test_single();
        do_reset();
        req      = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'h55};
        tx_ready = 1'b1;
        step();
        tests_run++;
        if (gnt !== 4'b0001) begin
            $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); tests_failed++;
        end
        tests_run++;
        if (tx_data !== 8'h55 || tx_valid !== 1'b1) begin
            $display("[TB] FAIL single_tx: got valid=%b data=%h expected valid=1 data=55", tx_valid, tx_data); tests_failed++;
        end
        req = 4'b0000;
        step();
        tests_run++;
        if (outstanding !== 3'd1 || credit_full !== 1'b0) begin
            $display("[TB] FAIL single_outstanding: got %0d full=%b expected 1 full=0", outstanding, credit_full); tests_failed++;
        end
        tests_run++;
        if (gnt !== 4'b0000 || tx_valid !== 1'b0) begin
            $display("[TB] FAIL single_after_accept: got gnt=%b valid=%b expected 0000/0", gnt, tx_valid); tests_failed++;
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tests_run++;
        if (outstanding !== 3'd0) begin
            $display("[TB] FAIL single_done: got %0d expected 0", outstanding); tests_failed++;
        end
    endtask

    // All four requesting, done returned after each accept: rotation 0,1,2,3,0.
    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic [7:0] exp_data [5];
        exp_gnt[0] = 4'b0001; exp_data[0] = 8'hA0;
        exp_gnt[1] = 4'b0010; exp_data[1] = 8'hA1;
        exp_gnt[2] = 4'b0100; exp_data[2] = 8'hA2;
        exp_gnt[3] = 4'b1000; exp_data[3] = 8'hA3;
        exp_gnt[4] = 4'b0001; exp_data[4] = 8'hA0;
        do_reset();
        req      = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tx_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            tx_done = 1'b0;
            tests_run++;
            if (gnt !== exp_gnt[k] || tx_data !== exp_data[k]) begin
                $display("[TB] FAIL rr_grant_%0d: got gnt=%b data=%h expected gnt=%b data=%h",
                         k, gnt, tx_data, exp_gnt[k], exp_data[k]);
                tests_failed++;
            end
            step();
            tests_run++;
            if (gnt !== 4'b0000 || outstanding !== 3'd1) begin
                $display("[TB] FAIL rr_accept_%0d: got gnt=%b outstanding=%0d expected 0000/1",
                         k, gnt, outstanding);
                tests_failed++;
            end
            tx_done = 1'b1;
        end
        req = 4'b0000;
        step();
        tx_done = 1'b0;
        tests_run++;
        if (outstanding !== 3'd0 || gnt !== 4'b0000) begin
            $display("[TB] FAIL rr_drain: got outstanding=%0d gnt=%b expected 0/0000", outstanding, gnt); tests_failed++;
        end
    endtask

    // No done returned: issue stops at four outstanding, resumes on one done.
    task automatic test_credit_limit();
        logic [3:0] exp_gnt [4];
        exp_gnt[0] = 4'b0001;
        exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0001;
        exp_gnt[3] = 4'b0010;
        do_reset();
        req      = 4'b0011;
        req_data = {8'h00, 8'h00, 8'h22, 8'h11};
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (gnt !== exp_gnt[k]) begin
                $display("[TB] FAIL credit_grant_%0d: got %b expected %b", k, gnt, exp_gnt[k]); tests_failed++;
            end
            step();
            tests_run++;
            if (outstanding !== 3'(k + 1)) begin
                $display("[TB] FAIL credit_count_%0d: got %0d expected %0d", k, outstanding, k + 1); tests_failed++;
            end
        end
        tests_run++;
        if (credit_full !== 1'b1) begin
            $display("[TB] FAIL credit_full_set: got %b expected 1", credit_full); tests_failed++;
        end
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (gnt !== 4'b0000 || tx_valid !== 1'b0) begin
                $display("[TB] FAIL credit_blocked_%0d: got gnt=%b valid=%b expected 0000/0", k, gnt, tx_valid); tests_failed++;
            end
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tests_run++;
        if (outstanding !== 3'd3 || credit_full !== 1'b0) begin
            $display("[TB] FAIL credit_release: got %0d full=%b expected 3 full=0", outstanding, credit_full); tests_failed++;
        end
        step();
        tests_run++;
        if (gnt !== 4'b0001) begin
            $display("[TB] FAIL credit_regrant: got %b expected 0001", gnt); tests_failed++;
        end
        req = 4'b0000;
        step();
        tests_run++;
        if (outstanding !== 3'd4 || credit_full !== 1'b1) begin
            $display("[TB] FAIL credit_refull: got %0d full=%b expected 4 full=1", outstanding, credit_full); tests_failed++;
        end
    endtask

    // Stalled transmitter holds the byte; accept and done together cancel.
    task automatic test_stall_and_cancel();
        do_reset();
        req      = 4'b0001;
        req_data = {8'h00, 8'h00, 8'hC3, 8'h5A};
        tx_ready = 1'b1;
        step();
        req = 4'b0000;
        step();
        req      = 4'b0010;
        tx_ready = 1'b0;
        step();
        req = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0010 || tx_data !== 8'hC3) begin
            $display("[TB] FAIL stall_grant: got gnt=%b data=%h expected 0010/c3", gnt, tx_data); tests_failed++;
        end
        for (int k = 0; k < 10; k++) begin
            step();
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hC3 || outstanding !== 3'd1) begin
                $display("[TB] FAIL stall_hold_%0d: got valid=%b data=%h outstanding=%0d expected 1/c3/1",
                         k, tx_valid, tx_data, outstanding);
                tests_failed++;
            end
        end
        tx_ready = 1'b1;
        tx_done  = 1'b1;
        step();
        tx_done  = 1'b0;
        tests_run++;
        if (outstanding !== 3'd1 || tx_valid !== 1'b0) begin
            $display("[TB] FAIL stall_cancel: got outstanding=%0d valid=%b expected 1/0", outstanding, tx_valid); tests_failed++;
        end
    endtask

    // Done with nothing outstanding: sticky error, count pinned at zero.
    task automatic test_underflow();
        do_reset();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tests_run++;
        if (underflow_err !== 1'b1 || outstanding !== 3'd0) begin
            $display("[TB] FAIL underflow_set: got err=%b outstanding=%0d expected 1/0", underflow_err, outstanding); tests_failed++;
        end
        req      = 4'b0100;
        req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        tx_ready = 1'b1;
        step();
        req = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0100 || tx_data !== 8'h77) begin
            $display("[TB] FAIL underflow_traffic_gnt: got gnt=%b data=%h expected 0100/77", gnt, tx_data); tests_failed++;
        end
        step();
        tests_run++;
        if (outstanding !== 3'd1 || underflow_err !== 1'b1) begin
            $display("[TB] FAIL underflow_persist: got outstanding=%0d err=%b expected 1/1", outstanding, underflow_err); tests_failed++;
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tests_run++;
        if (outstanding !== 3'd0 || underflow_err !== 1'b1) begin
            $display("[TB] FAIL underflow_persist2: got outstanding=%0d err=%b expected 0/1", outstanding, underflow_err); tests_failed++;
        end
        do_reset();
        tests_run++;
        if (underflow_err !== 1'b0) begin
            $display("[TB] FAIL underflow_clear: got %b expected 0", underflow_err); tests_failed++;
        end
    endtask

    // Asynchronous reset in the middle of ISSUE with two bytes outstanding.
    task automatic test_async_reset();
        do_reset();
        tx_done = 1'b1;
        step();
        tx_done  = 1'b0;
        req      = 4'b0011;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tx_ready = 1'b1;
        step();
        step();
        step();
        step();
        req      = 4'b0100;
        tx_ready = 1'b0;
        step();
        req = 4'b0000;
        tests_run++;
        if (outstanding !== 3'd2 || tx_valid !== 1'b1 || gnt !== 4'b0100 || underflow_err !== 1'b1) begin
            $display("[TB] FAIL areset_setup: got outstanding=%0d valid=%b gnt=%b err=%b expected 2/1/0100/1",
                     outstanding, tx_valid, gnt, underflow_err);
            tests_failed++;
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (tx_valid !== 1'b0 || gnt !== 4'b0000 || tx_data !== 8'h00) begin
            $display("[TB] FAIL areset_tx: got valid=%b gnt=%b data=%h expected 0/0000/00", tx_valid, gnt, tx_data); tests_failed++;
        end
        tests_run++;
        if (outstanding !== 3'd0 || credit_full !== 1'b0 || underflow_err !== 1'b0) begin
            $display("[TB] FAIL areset_count: got outstanding=%0d full=%b err=%b expected 0/0/0",
                     outstanding, credit_full, underflow_err);
            tests_failed++;
        end
        step();
        rst      = 1'b0;
        req      = 4'b1111;
        tx_ready = 1'b1;
        step();
        req = 4'b0000;
        tests_run++;
        if (gnt !== 4'b0001 || tx_data !== 8'h11) begin
            $display("[TB] FAIL areset_first_grant: got gnt=%b data=%h expected 0001/11", gnt, tx_data); tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_ready = 1'b0;
        tx_done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_credit_limit();
        test_stall_and_cancel();
        test_underflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
